// File: rtl/key_conditioner_pkg.sv
// Shared types and default timing for the front-panel key conditioner.
// Repeat-FSM state encodings and ms-based timing defaults.
package key_conditioner_pkg;

   typedef enum logic [1:0] {
      ST_UP   = 2'd0,
      ST_DOWN = 2'd1,
      ST_RPT  = 2'd2
   } rpt_state_e;

   localparam int unsigned DEF_NKEYS    = 4;
   localparam int unsigned DEF_CLK_HZ   = 100_000_000;
   localparam int unsigned DEF_TICK_HZ  = 1000;
   localparam int unsigned DEF_DEB_MS   = 20;
   localparam int unsigned DEF_HOLD_MS  = 800;
   localparam int unsigned DEF_REP_MS   = 200;
   localparam logic [3:0]  DEF_REP_MASK = 4'b0011;

   function automatic int unsigned max2(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/key_conditioner_channel.sv
// One key channel: 2-flop synchroniser, tick-based debounce, edge pulses
// and the UP/DOWN/RPT auto-repeat state machine.
module key_channel
   import key_conditioner_pkg::*;
#(
   parameter int unsigned DEB_MS  = DEF_DEB_MS,
   parameter int unsigned HOLD_MS = DEF_HOLD_MS,
   parameter int unsigned REP_MS  = DEF_REP_MS
) (
   input  logic clk_100m,
   input  logic cr,
   input  logic tick,
   input  logic raw,
   input  logic rep_en,
   output logic level,
   output logic press,
   output logic rel,
   output logic step
);

   localparam int unsigned DW = $clog2(DEB_MS + 1);
   localparam int unsigned HW = $clog2(max2(HOLD_MS, REP_MS) + 1);

   logic          sync1_q, sync2_q;
   logic          level_q, level_d, prev_q;
   logic [DW-1:0] deb_q, deb_d;
   logic [HW-1:0] hcnt_q, hcnt_d;
   rpt_state_e    state_q, state_d;
   logic          rise, fall;

   always_ff @(posedge clk_100m or posedge cr) begin
      if (cr) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         prev_q  <= 1'b0;
         deb_q   <= '0;
         hcnt_q  <= '0;
         state_q <= ST_UP;
      end else begin
         sync1_q <= raw;
         sync2_q <= sync1_q;
         level_q <= level_d;
         prev_q  <= level_q;
         deb_q   <= deb_d;
         hcnt_q  <= hcnt_d;
         state_q <= state_d;
      end
   end

   // Count reaching DEB_MS on this tick toggles the level in the same edge.
   always_comb begin
      level_d = level_q;
      deb_d   = deb_q;
      if (sync2_q == level_q) begin
         deb_d = '0;
      end else if (tick) begin
         if (deb_q == DW'(DEB_MS - 1)) begin
            level_d = ~level_q;
            deb_d   = '0;
         end else begin
            deb_d = deb_q + 1'b1;
         end
      end
   end

   assign rise = level_q & ~prev_q;
   assign fall = ~level_q & prev_q;

   // A falling level overrides any step, including a coincident repeat expiry.
   always_comb begin
      state_d = state_q;
      hcnt_d  = hcnt_q;
      step    = 1'b0;
      if (fall) begin
         state_d = ST_UP;
         hcnt_d  = '0;
      end else begin
         case (state_q)
            ST_UP: begin
               if (rise) begin
                  state_d = ST_DOWN;
                  step    = 1'b1;
                  hcnt_d  = '0;
               end
            end
            ST_DOWN: begin
               if (rep_en && (hcnt_q == HW'(HOLD_MS))) begin
                  state_d = ST_RPT;
                  step    = 1'b1;
                  hcnt_d  = '0;
               end else if (tick && (hcnt_q != HW'(HOLD_MS))) begin
                  hcnt_d = hcnt_q + 1'b1;
               end
            end
            ST_RPT: begin
               if (hcnt_q == HW'(REP_MS)) begin
                  step   = 1'b1;
                  hcnt_d = '0;
               end else if (tick) begin
                  hcnt_d = hcnt_q + 1'b1;
               end
            end
            default: begin
               state_d = ST_UP;
               hcnt_d  = '0;
            end
         endcase
      end
   end

   assign level = level_q;
   assign press = rise;
   assign rel   = fall;

endmodule

// File: rtl/key_conditioner.sv
// Front-panel key conditioner: shared ms sample-tick prescaler feeding
// NKEYS independent debounce/auto-repeat channels.
module key_conditioner
   import key_conditioner_pkg::*;
#(
   parameter int unsigned      NKEYS    = DEF_NKEYS,
   parameter int unsigned      CLK_HZ   = DEF_CLK_HZ,
   parameter int unsigned      TICK_HZ  = DEF_TICK_HZ,
   parameter int unsigned      DEB_MS   = DEF_DEB_MS,
   parameter int unsigned      HOLD_MS  = DEF_HOLD_MS,
   parameter int unsigned      REP_MS   = DEF_REP_MS,
   parameter logic [NKEYS-1:0] REP_MASK = NKEYS'(DEF_REP_MASK)
) (
   input  logic             clk_100m,
   input  logic             cr,
   input  logic [NKEYS-1:0] key_raw,
   output logic [NKEYS-1:0] key_level,
   output logic [NKEYS-1:0] key_press,
   output logic [NKEYS-1:0] key_release,
   output logic [NKEYS-1:0] key_step
);

   localparam int unsigned TC = CLK_HZ / TICK_HZ - 1;
   localparam int unsigned PW = max2($clog2(TC + 1), 1);

   logic [PW-1:0] pre_q, pre_d;
   logic          tick;

   always_ff @(posedge clk_100m or posedge cr) begin
      if (cr) begin
         pre_q <= '0;
      end else begin
         pre_q <= pre_d;
      end
   end

   always_comb begin
      tick  = (pre_q == PW'(TC));
      pre_d = tick ? '0 : pre_q + 1'b1;
   end

   for (genvar i = 0; i < NKEYS; i++) begin : g_key
      key_channel #(
         .DEB_MS (DEB_MS),
         .HOLD_MS(HOLD_MS),
         .REP_MS (REP_MS)
      ) u_chan (
         .clk_100m(clk_100m),
         .cr      (cr),
         .tick    (tick),
         .raw     (key_raw[i]),
         .rep_en  (REP_MASK[i]),
         .level   (key_level[i]),
         .press   (key_press[i]),
         .rel     (key_release[i]),
         .step    (key_step[i])
      );
   end

endmodule
